// File: rtl/fft_pkg.sv
// Shared sample width and sample type for the FFT front end.
package fft_pkg;
  localparam int unsigned WIDTH = 16;
  typedef logic signed [WIDTH-1:0] sample_t;
endpackage

// File: rtl/fft_feeder_if.sv
// Sample-in / bin-out stream bundle for fft_feeder.
// slave = the feeder itself, master = the upstream/downstream environment.
interface fft_feeder_if;
  import fft_pkg::*;

  sample_t    s_data;
  logic       s_valid;
  logic       s_ready;
  sample_t    m_data;
  logic [1:0] m_bin;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_bin, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_bin, m_valid, m_last
  );
endinterface

// File: rtl/fft_feeder.sv
// Collects 4-sample frames, launches a combinational FFT engine and streams its 4 bins out.
// Optional FFT_FEEDER_OVERLAP_EN: a second sample buffer fills the next frame during DRAIN.
module fft_feeder
  import fft_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  fft_feeder_if.slave bus,
  output sample_t     fft_in [3:0],
  output logic        fft_start,
  output logic        fft_rst,
  input  sample_t     fft_out [3:0],
  input  logic        fft_valid,
  output logic        err_timeout
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [TW-1:0] wait_cnt;
  sample_t       obuf [3:0];
  logic          s_beat;
  logic          m_beat;

  assign s_beat = bus.s_valid & bus.s_ready;
  assign m_beat = bus.m_valid & bus.m_ready;

`ifdef FFT_FEEDER_OVERLAP_EN
  sample_t  nbuf [3:0];
  sample_t  nview [3:0];
  logic [2:0] ncnt;
  logic [2:0] ncnt_nxt;
  logic       d_beat;

  // Second buffer as it will look after this edge, including a beat landing now.
  always_comb begin
    d_beat   = s_beat && (state == DRAIN);
    ncnt_nxt = ncnt + 3'(d_beat);
    for (int i = 0; i < 4; i++) nview[i] = nbuf[i];
    if (d_beat) nview[ncnt[1:0]] = bus.s_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FILL;
      cnt         <= '0;
      wait_cnt    <= '0;
      for (int i = 0; i < 4; i++) begin
        fft_in[i] <= '0;
        obuf[i]   <= '0;
      end
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_bin   <= '0;
      bus.m_data  <= '0;
      fft_start   <= 1'b0;
      fft_rst     <= 1'b1;
      err_timeout <= 1'b0;
`ifdef FFT_FEEDER_OVERLAP_EN
      ncnt        <= '0;
      for (int i = 0; i < 4; i++) nbuf[i] <= '0;
`endif
    end else begin
      fft_start   <= 1'b0;
      fft_rst     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        FILL: begin
          bus.s_ready <= 1'b1;
          if (s_beat) begin
            fft_in[cnt] <= bus.s_data;
            cnt         <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state       <= LAUNCH;
              fft_start   <= 1'b1;
              bus.s_ready <= 1'b0;
            end
          end
        end
        LAUNCH: begin
          state       <= WAIT;
          wait_cnt    <= '0;
          err_timeout <= (TIMEOUT == 1);
        end
        // err_timeout is raised so that it is visible in the last WAIT cycle; bins arriving then are ignored.
        WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state       <= FILL;
            cnt         <= '0;
            fft_rst     <= 1'b1;
            bus.s_ready <= 1'b1;
          end else if (fft_valid) begin
            obuf        <= fft_out;
            state       <= DRAIN;
            fft_rst     <= 1'b1;
            bus.m_valid <= 1'b1;
            bus.m_bin   <= '0;
            bus.m_data  <= fft_out[0];
            bus.m_last  <= 1'b0;
`ifdef FFT_FEEDER_OVERLAP_EN
            bus.s_ready <= 1'b1;
`endif
          end else if (wait_cnt == TW'(TIMEOUT - 2)) begin
            err_timeout <= 1'b1;
          end
        end
        DRAIN: begin
`ifdef FFT_FEEDER_OVERLAP_EN
          if (d_beat) begin
            nbuf[ncnt[1:0]] <= bus.s_data;
            ncnt            <= ncnt_nxt;
          end
          bus.s_ready <= (ncnt_nxt != 3'd4);
`endif
          if (m_beat) begin
            if (bus.m_bin == 2'd3) begin
              bus.m_valid <= 1'b0;
              bus.m_last  <= 1'b0;
              bus.m_bin   <= '0;
              bus.m_data  <= '0;
`ifdef FFT_FEEDER_OVERLAP_EN
              fft_in <= nview;
              ncnt   <= '0;
              if (ncnt_nxt == 3'd4) begin
                state       <= LAUNCH;
                fft_start   <= 1'b1;
                bus.s_ready <= 1'b0;
              end else begin
                state       <= FILL;
                cnt         <= ncnt_nxt[1:0];
                bus.s_ready <= 1'b1;
              end
`else
              state       <= FILL;
              cnt         <= '0;
              bus.s_ready <= 1'b1;
`endif
            end else begin
              bus.m_bin  <= bus.m_bin + 2'd1;
              bus.m_data <= obuf[bus.m_bin + 2'd1];
              bus.m_last <= (bus.m_bin == 2'd2);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_feeder.sv
// Directed + randomized bench for fft_feeder with a behavioural 4-point FFT engine alongside.
module tb_fft_feeder;
  import fft_pkg::*;

  localparam int unsigned TO = 8;
`ifdef FFT_FEEDER_OVERLAP_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  sample_t fft_in [3:0];
  sample_t fft_out [3:0];
  logic    fft_start, fft_rst, err_timeout;
  logic    fft_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_feeder_if bus();

  fft_feeder #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fft_in      (fft_in),
    .fft_start   (fft_start),
    .fft_rst     (fft_rst),
    .fft_out     (fft_out),
    .fft_valid   (fft_valid),
    .err_timeout (err_timeout)
  );

  // Real-valued 4-point DFT: X0, Re X1, X2, Im X1.
  function automatic sample_t bin_of(input sample_t a, b, c, d, input int k);
    case (k)
      0:       return sample_t'(a + b + c + d);
      1:       return sample_t'(a - c);
      2:       return sample_t'(a - b + c - d);
      default: return sample_t'(d - b);
    endcase
  endfunction

  // Engine: bins are combinational on fft_in; fft_valid rises 3 cycles after fft_start and holds until fft_rst.
  bit engine_dead = 1'b0;
  bit eng_busy    = 1'b0;
  int eng_cnt     = 0;

  always_comb for (int i = 0; i < 4; i++) fft_out[i] = bin_of(fft_in[0], fft_in[1], fft_in[2], fft_in[3], i);

  always @(posedge clk) begin
    if (fft_rst === 1'b1) begin
      eng_busy  <= 1'b0;
      eng_cnt   <= 0;
      fft_valid <= 1'b0;
    end else if (fft_start === 1'b1 && !eng_busy) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 1;
    end else if (eng_busy && !fft_valid) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 2 && !engine_dead) fft_valid <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst s_ready", 32'(bus.s_ready), 0);
    chk("rst fft_start", 32'(fft_start), 0);
    chk("rst fft_rst", 32'(fft_rst), 1);
    chk("rst m_valid", 32'(bus.m_valid), 0);
    chk("rst m_last", 32'(bus.m_last), 0);
    chk("rst m_bin", 32'(bus.m_bin), 0);
    chk("rst m_data", 32'(bus.m_data), 0);
    chk("rst err_timeout", 32'(err_timeout), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst fft_in%0d", i), 32'(fft_in[i]), 0);
  endtask

  // Offer 4 samples; returns at the negedge right after the 4th beat.
  task automatic send_frame(input sample_t smp [4], input bit gapped);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = smp[i];
      while (bus.s_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("s_ready wait", 32'(bus.s_ready), 1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      if (gapped && i < 3) @(negedge clk);
    end
  endtask

  task automatic check_launch(input sample_t smp [4]);
    chk("launch fft_start", 32'(fft_start), 1);
    chk("launch s_ready", 32'(bus.s_ready), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("launch fft_in%0d", i), 32'(fft_in[i]), 32'(smp[i]));
  endtask

  // From the LAUNCH negedge: 3 WAIT cycles, then drain 4 bins with an optional stall.
  task automatic after_launch(input sample_t smp [4], input int stall_bin, input int stall_n);
    sample_t expv [4];
    for (int k = 0; k < 4; k++) expv[k] = bin_of(smp[0], smp[1], smp[2], smp[3], k);
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      chk($sformatf("wait%0d m_valid", w), 32'(bus.m_valid), 0);
      chk($sformatf("wait%0d fft_start", w), 32'(fft_start), 0);
      chk($sformatf("wait%0d s_ready", w), 32'(bus.s_ready), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("wait fft_in%0d", i), 32'(fft_in[i]), 32'(smp[i]));
    end
    @(negedge clk);
    chk("drain1 fft_rst", 32'(fft_rst), 1);
    chk("drain1 s_ready", 32'(bus.s_ready), 32'(OVL));
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("bin%0d m_valid", b), 32'(bus.m_valid), 1);
      chk($sformatf("bin%0d m_bin", b), 32'(bus.m_bin), 32'(b));
      chk($sformatf("bin%0d m_data", b), 32'(bus.m_data), 32'(expv[b]));
      chk($sformatf("bin%0d m_last", b), 32'(bus.m_last), 32'(b == 3));
      if (b == 1) chk("drain2 fft_rst", 32'(fft_rst), 0);
      if (b == stall_bin) begin
        bus.m_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk($sformatf("hold%0d m_bin", b), 32'(bus.m_bin), 32'(b));
          chk($sformatf("hold%0d m_data", b), 32'(bus.m_data), 32'(expv[b]));
          chk($sformatf("hold%0d m_last", b), 32'(bus.m_last), 32'(b == 3));
        end
        bus.m_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("post m_valid", 32'(bus.m_valid), 0);
    chk("post s_ready", 32'(bus.s_ready), 1);
    chk("post fft_rst", 32'(fft_rst), 0);
  endtask

  task automatic run_frame(input sample_t smp [4], input bit gapped, input int stall_bin, input int stall_n);
    send_frame(smp, gapped);
    check_launch(smp);
    after_launch(smp, stall_bin, stall_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t f [4];
    sample_t g [4];

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    rst         = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b1;
    @(negedge clk);
    chk("release fft_rst", 32'(fft_rst), 0);
    chk("release s_ready", 32'(bus.s_ready), 1);

    // Basic frame 1,2,3,4
    for (int i = 0; i < 4; i++) f[i] = sample_t'(i + 1);
    run_frame(f, 1'b0, -1, 0);

    // Backpressure at bin 1 for 5 cycles
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    run_frame(f, 1'b0, 1, 5);

    // Gapped input
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    run_frame(f, 1'b1, -1, 0);

    // Timeout: engine never answers
    engine_dead = 1'b1;
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    send_frame(f, 1'b0);
    check_launch(f);
    for (int w = 1; w <= int'(TO); w++) begin
      @(negedge clk);
      chk($sformatf("to wait%0d err", w), 32'(err_timeout), 32'(w == int'(TO)));
      chk($sformatf("to wait%0d s_ready", w), 32'(bus.s_ready), 0);
      chk($sformatf("to wait%0d m_valid", w), 32'(bus.m_valid), 0);
    end
    @(negedge clk);
    chk("to after err", 32'(err_timeout), 0);
    chk("to after s_ready", 32'(bus.s_ready), 1);
    chk("to after fft_rst", 32'(fft_rst), 1);
    chk("to after m_valid", 32'(bus.m_valid), 0);
    engine_dead = 1'b0;
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    run_frame(f, 1'b0, -1, 0);

    // Reset in the middle of WAIT
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    send_frame(f, 1'b0);
    check_launch(f);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst fft_rst", 32'(fft_rst), 0);
    chk("mid-rst s_ready", 32'(bus.s_ready), 1);
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    run_frame(f, 1'b0, -1, 0);

    // Randomized frames
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
      run_frame(f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)) - 1,
                int'($urandom_range(1, 4)));
    end

`ifdef FFT_FEEDER_OVERLAP_EN
    // Next frame arrives while the current one drains
    for (int i = 0; i < 4; i++) f[i] = sample_t'($urandom);
    for (int i = 0; i < 4; i++) g[i] = sample_t'($urandom);
    send_frame(f, 1'b0);
    check_launch(f);
    repeat (4) @(negedge clk);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovl s_ready%0d", i), 32'(bus.s_ready), 1);
      bus.s_valid = 1'b1;
      bus.s_data  = g[i];
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk("ovl s_ready full", 32'(bus.s_ready), 0);
    bus.m_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("ovl bin%0d", b), 32'(bus.m_data), 32'(bin_of(f[0], f[1], f[2], f[3], b)));
      @(negedge clk);
    end
    check_launch(g);
    after_launch(g, -1, 0);
`else
    g = f;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_feeder.md
FFT_FEEDER -- requirements
Module: fft_feeder

Interface
- REQ-001 The block SHALL have parameter TIMEOUT, default 8, giving the maximum cycles from fft_start to fft_valid.
- REQ-002 The block SHALL take WIDTH from fft_pkg and SHALL NOT declare it locally.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
- REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
- REQ-005 The block SHALL have port s_data, input, signed WIDTH bits: audio sample.
- REQ-006 The block SHALL have port s_valid, input, 1 bit: sample offered.
- REQ-007 The block SHALL have port s_ready, output, 1 bit: sample accepted when s_valid is also high.
- REQ-008 The block SHALL have port fft_in[3:0], output, signed WIDTH bits each: frame to the FFT.
- REQ-009 The block SHALL have port fft_start, output, 1 bit: FFT launch pulse.
- REQ-010 The block SHALL have port fft_rst, output, 1 bit: active-high FFT engine reset.
- REQ-011 The block SHALL have port fft_out[3:0], input, signed WIDTH bits each: FFT bins.
- REQ-012 The block SHALL have port fft_valid, input, 1 bit: bins valid. The engine holds this high until it is reset.
- REQ-013 The block SHALL have port m_data, output, signed WIDTH bits: bin value.
- REQ-014 The block SHALL have port m_bin, output, 2 bits: bin index.
- REQ-015 The block SHALL have ports m_valid (output), m_ready (input) and m_last (output), 1 bit each: output stream handshake; m_last marks bin 3.
- REQ-016 The block SHALL have port err_timeout, output, 1 bit: one-cycle timeout pulse.

Function
- REQ-017 The FSM SHALL have states FILL, LAUNCH, WAIT, DRAIN.
- REQ-018 FILL: s_ready=1, and each s_valid&&s_ready beat SHALL write sample buffer slot cnt (0..3).
- REQ-019 After the beat that writes slot 3, the FSM SHALL move to LAUNCH.
- REQ-020 LAUNCH SHALL last exactly 1 cycle with fft_start=1 and then move to WAIT.
- REQ-021 fft_in SHALL equal the sample buffer and SHALL stay stable from LAUNCH until fft_valid is captured; the engine datapath is combinational.
- REQ-022 WAIT: the first cycle with fft_valid=1 SHALL register fft_out[3:0] into an output buffer and move to DRAIN.
- REQ-023 With the companion engine, fft_valid SHALL be seen 3 cycles after fft_start.
- REQ-024 In the first DRAIN cycle, fft_rst SHALL be 1 for exactly 1 cycle, returning the engine to idle.
- REQ-025 DRAIN SHALL present bins 0,1,2,3 in order, with m_valid=1, m_bin=index and m_last=(index==3).
- REQ-026 In DRAIN, the bin SHALL advance only on m_valid&&m_ready.
- REQ-027 While m_ready=0, m_data, m_bin and m_last SHALL hold stable.
- REQ-028 After the handshake of bin 3, the FSM SHALL move to FILL.
- REQ-029 If WAIT lasts TIMEOUT cycles without fft_valid, err_timeout SHALL pulse 1 cycle, fft_rst SHALL pulse 1 cycle, the frame SHALL be discarded and the FSM SHALL move to FILL with cnt=0.
- REQ-030 s_ready SHALL be 0 in LAUNCH and WAIT.
- REQ-031 m_valid SHALL be 0 outside DRAIN.
- REQ-032 Arithmetic SHALL be pass-through only; there is no scaling or truncation.

Reset
- REQ-033 When rst=0 at a clk edge, the state SHALL become FILL and cnt=0.
- REQ-034 During reset, outputs SHALL be: s_ready=0, fft_start=0, fft_rst=1, m_valid=0, m_last=0, m_bin=0, m_data=0, err_timeout=0, fft_in all 0.
- REQ-035 Reset mid-frame (any state) SHALL discard all buffered samples and bins.
- REQ-036 After reset, the first cycle SHALL have fft_rst=0 and s_ready=1.

Configuration
- REQ-037 With FFT_FEEDER_OVERLAP_EN defined, the block SHALL have a second sample buffer, and s_ready SHALL also be 1 in DRAIN, filling the next frame.
- REQ-038 With FFT_FEEDER_OVERLAP_EN defined, if that buffer holds 4 samples when bin 3 handshakes, the FSM SHALL move directly to LAUNCH.
- REQ-039 With FFT_FEEDER_OVERLAP_EN defined, s_ready SHALL drop to 0 once the second buffer is full.
- REQ-040 Without FFT_FEEDER_OVERLAP_EN, s_ready SHALL be 0 in DRAIN and there SHALL be a single buffer.

Verification
- REQ-041 Basic frame: samples 1,2,3,4 with m_ready=1 and the real engine -> fft_start 1 cycle after the 4th beat; bins 0..3 match the engine outputs; m_last on bin 3; fft_rst pulses once.
- REQ-042 Backpressure: m_ready=0 for 5 cycles at bin 1 -> m_bin=1 and m_data held for 5 cycles; no bin lost.
- REQ-043 Timeout: the engine model never asserts fft_valid -> err_timeout is high on cycle 8 of WAIT; FSM returns to FILL; s_ready=1 next cycle.
- REQ-044 Reset mid-WAIT: rst=0 for 1 cycle -> all outputs at reset values; the following 4 samples form a fresh frame.
- REQ-045 Gapped input: s_valid toggling 1,0,1,0 -> exactly 4 accepted beats per frame, in slot order.
- REQ-046 Overlap (FFT_FEEDER_OVERLAP_EN defined): samples 5..8 arrive during DRAIN -> LAUNCH on the cycle after the bin 3 handshake, with no FILL cycles.
